fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Synchronous, parametrised instruction fetch stage between the PC/branch logic, the instruction ROM and decode. It is the clocked successor of the toggle-handshake fetch stage. Instead of fetching one word per decode trigger, it prefetches sequential words into a DEPTH-entry FIFO. It hands each word to decode with its PC over a valid/ready handshake and flushes on a redirect, including any ROM read already in flight.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 32, PC / ROM address width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- PC_STEP, 1, PC increment per fetched word (word addressing)
- RESET_PC, 0, first fetch address after reset

- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rom_req  out  1  ROM read request; held high until acknowledged
- rom_addr  out  ADDR_W  ROM read address; stable while rom_req is high
- rom_ack  in  1  one-cycle pulse; rom_data is valid in that cycle
- rom_data  in  DATA_W  ROM read data
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  decode accepts the head
- out_data  out  DATA_W  instruction word at the FIFO head
- out_pc  out  ADDR_W  address the head word was fetched from
- redir_valid  in  1  one-cycle redirect (branch) strobe
- redir_pc  in  ADDR_W  new fetch PC

## Operation
- **State:** fetch PC `pc`, FIFO `{pc, data}` × DEPTH, `count` (0..DEPTH), `inflight` flag, `discard` flag.
- **Reset (rst_n low, async):**
  - pc=RESET_PC; count=0; inflight=0; discard=0
  - Outputs: rom_req=0, rom_addr=0, out_valid=0, out_data=0, out_pc=0.
- **Issue:** the block issues a new request only if redir_valid=0 and `count_next + 1 ≤ DEPTH`. count_next is count after this edge's push/pop, and a slot is reserved for the new request. It may issue:
  - when inflight=0, or
  - in the same edge that acknowledges the current request.
- **On issue:**
  - rom_addr←pc, pc←pc+PC_STEP (wraps mod 2^ADDR_W)
  - rom_req←1, inflight←1
- **Acknowledge:** rom_ack is sampled only while rom_req=1; an ack while rom_req=0 is ignored.
  - If discard=0: push `{rom_addr, rom_data}`.
  - Either way: inflight←0, discard←0.
  - rom_req drops on the ack edge unless a back-to-back issue occurs in that same edge.
- **Pop:** occurs when out_valid && out_ready. Push and pop in the same edge leave count unchanged.
- **Redirect (redir_valid=1):**
  - count←0 (FIFO flushed); pc←redir_pc; no issue this edge.
  - If a request is in flight and not acked this edge: discard←1.
  - A pending request is never abandoned; rom_req and rom_addr stay unchanged until its ack, and that data is dropped.
  - If rom_ack arrives in the same edge as the redirect, its data is dropped.
  - A pop in the redirect cycle counts as consumed by decode; out_valid=0 after the edge.
- **FIFO overflow** cannot occur given the issue rule. Popping an empty FIFO is impossible because out_valid=0.

## Timing
- All outputs are registered or driven directly from registers; there are no combinational paths from inputs to outputs.
- **First request:** rom_req=1 after the first rising edge with rst_n high.
- **Fetch latency:** ROM ack at edge E → out_valid=1 after E, when the FIFO was empty.
- **Throughput:** with rom_ack held high every cycle and decode always ready, one word per cycle and rom_req stays high continuously.
- **Redirect:** redirect at edge R with no in-flight request → the request for redir_pc is issued at edge R+1. With an in-flight request, it is issued at the ack edge of the discarded request, or at R+1 if that ack coincides with R.
- **Backpressure:** with out_ready=0, the block issues exactly DEPTH requests (including in-flight) and then holds rom_req=0.

## Test plan
- **Reset/first fetch:** rst_n release, ROM acks 1 cycle after each req, out_ready=1 → rom_addr sequence 0,1,2,3; out_pc/out_data match the ROM image; out_valid first rises 2 edges after reset release.
- **Full backpressure:** out_ready=0, DEPTH=4 → exactly 4 acks; count=4, rom_req=0. Then assert out_ready → words at PCs 0..3 delivered in order and fetching resumes at 4.
- **Redirect with in-flight request:** ack delayed 3 cycles, redirect to 0x40 one cycle after req → rom_addr is held until ack, that ack's data is dropped, the next rom_addr is 0x40, and the first out_pc is 0x40.
- **Simultaneous ack and redirect:** redirect to 0x100 in the rom_ack cycle → no push, FIFO empty, next rom_addr=0x100.
- **Back-to-back:** rom_ack held high, out_ready=1 → rom_req never drops; one word per cycle with consecutive out_pc values.
- **Async reset mid-operation:** drop rst_n between clock edges while inflight=1 and count=3 → all outputs reach reset values immediately; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_if.sv
// Bundle of ROM read port, decode output handshake and branch redirect strobe
// for the prefetching fetch stage.
interface fetch_prefetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_pc;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;

    modport master (
        output rom_req, rom_addr, out_valid, out_data, out_pc,
        input  rom_ack, rom_data, out_ready, redir_valid, redir_pc
    );

    modport slave (
        input  rom_req, rom_addr, out_valid, out_data, out_pc,
        output rom_ack, rom_data, out_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: prefetches sequential ROM words into a small FIFO and
// hands {pc, word} to decode; a redirect flushes the FIFO and drops any in-flight read.
module fetch_prefetch #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              rst_n,
    fetch_prefetch_if.master fp_io
);
    localparam int unsigned       PtrW   = $clog2(DEPTH);
    localparam int unsigned       CntW   = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0]   DepthC = CntW'(DEPTH);
    localparam logic [ADDR_W-1:0] StepC  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              inflight_q, inflight_d;
    logic              discard_q, discard_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic ack, push, pop, issue, head_valid;

    always_comb begin
        head_valid = (count_q != '0);
        ack        = inflight_q & fp_io.rom_ack;
        push       = ack & ~discard_q & ~fp_io.redir_valid;
        pop        = head_valid & fp_io.out_ready;

        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (fp_io.redir_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Issuing reserves a slot, so the post-edge count must leave room for it.
        issue = ~fp_io.redir_valid & (count_d < DepthC) & (~inflight_q | ack);

        pc_d       = pc_q;
        rom_addr_d = rom_addr_q;
        if (fp_io.redir_valid) begin
            pc_d = fp_io.redir_pc;
        end else if (issue) begin
            pc_d       = pc_q + StepC;
            rom_addr_d = pc_q;
        end

        inflight_d = inflight_q;
        if (issue)    inflight_d = 1'b1;
        else if (ack) inflight_d = 1'b0;

        // A redirect never cancels the bus request; the stale reply is dropped instead.
        discard_d = discard_q;
        if (ack)                                   discard_d = 1'b0;
        else if (fp_io.redir_valid && inflight_q)  discard_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rom_addr_q <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            rom_addr_q <= rom_addr_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= fp_io.rom_data;
            pc_mem_q[wr_ptr_q]   <= rom_addr_q;
        end
    end

    assign fp_io.rom_req   = inflight_q;
    assign fp_io.rom_addr  = rom_addr_q;
    assign fp_io.out_valid = head_valid;
    assign fp_io.out_data  = head_valid ? data_mem_q[rd_ptr_q] : '0;
    assign fp_io.out_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a small ROM responder with programmable ack
// delay, stepped from one initial block; outputs are checked on the falling edge.
module tb_fetch_prefetch;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   wcnt;
    int   ack_delay;
    int   n_ack;

    fetch_prefetch_if #(.DATA_W(32), .ADDR_W(32)) fp ();

    fetch_prefetch #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (4),
        .PC_STEP (1),
        .RESET_PC(32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fp_io(fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ROM answers after ack_delay cycles of a visible request, one-cycle ack pulse.
    task automatic rom_update();
        if (fp.rom_req === 1'b1 && wcnt == ack_delay) begin
            fp.rom_ack  = 1'b1;
            fp.rom_data = rom_word(fp.rom_addr);
            wcnt        = 0;
            n_ack++;
        end else begin
            fp.rom_ack = 1'b0;
            if (fp.rom_req === 1'b1) wcnt++;
            else wcnt = 0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rom_update();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fp.rom_ack = 1'b0;
        wcnt       = 0;
        cyc();
        rst_n = 1'b1;
        n_ack = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; wcnt = 0; n_ack = 0; ack_delay = 0;
        rst_n          = 1'b0;
        fp.rom_ack     = 1'b0;
        fp.rom_data    = '0;
        fp.out_ready   = 1'b1;
        fp.redir_valid = 1'b0;
        fp.redir_pc    = '0;

        // Reset state, then first fetch with immediate acks and decode always ready.
        cyc();
        chk("rst_rom_req",   fp.rom_req,   0);
        chk("rst_rom_addr",  fp.rom_addr,  0);
        chk("rst_out_valid", fp.out_valid, 0);
        chk("rst_out_data",  fp.out_data,  0);
        chk("rst_out_pc",    fp.out_pc,    0);
        rst_n = 1'b1;
        cyc();
        chk("first_req",   fp.rom_req,   1);
        chk("first_addr",  fp.rom_addr,  0);
        chk("first_valid", fp.out_valid, 0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("b2b_valid", fp.out_valid, 1);
            chk("b2b_pc",    fp.out_pc,    k);
            chk("b2b_data",  fp.out_data,  rom_word(k));
            chk("b2b_req",   fp.rom_req,   1);
            chk("b2b_addr",  fp.rom_addr,  k + 1);
        end

        // Full backpressure: exactly DEPTH reads, then the request line idles.
        fp.out_ready = 1'b0;
        ack_delay    = 0;
        do_reset();
        repeat (10) cyc();
        chk("bp_acks",  n_ack,         4);
        chk("bp_req",   fp.rom_req,    0);
        chk("bp_valid", fp.out_valid,  1);
        chk("bp_pc",    fp.out_pc,     0);
        chk("bp_data",  fp.out_data,   rom_word(0));
        fp.out_ready = 1'b1;
        cyc();
        chk("bp_resume_pc",   fp.out_pc,   1);
        chk("bp_resume_req",  fp.rom_req,  1);
        chk("bp_resume_addr", fp.rom_addr, 4);
        for (int k = 2; k < 7; k++) begin
            cyc();
            chk("bp_drain_pc",   fp.out_pc,   k);
            chk("bp_drain_data", fp.out_data, rom_word(k));
        end

        // Redirect while a slow read is in flight: address held, reply dropped.
        ack_delay    = 3;
        fp.out_ready = 1'b1;
        do_reset();
        cyc();
        chk("rd_req0", fp.rom_addr, 0);
        fp.redir_valid = 1'b1;
        fp.redir_pc    = 32'h40;
        cyc();
        fp.redir_valid = 1'b0;
        chk("rd_hold_req",  fp.rom_req,   1);
        chk("rd_hold_addr", fp.rom_addr,  0);
        chk("rd_flush",     fp.out_valid, 0);
        cyc();
        chk("rd_hold_addr2", fp.rom_addr, 0);
        cyc();
        chk("rd_hold_addr3", fp.rom_addr, 0);
        cyc();
        chk("rd_new_addr", fp.rom_addr,  32'h40);
        chk("rd_new_req",  fp.rom_req,   1);
        chk("rd_dropped",  fp.out_valid, 0);
        repeat (4) cyc();
        chk("rd_out_valid", fp.out_valid, 1);
        chk("rd_out_pc",    fp.out_pc,    32'h40);
        chk("rd_out_data",  fp.out_data,  rom_word(32'h40));

        // Redirect in the same cycle as the ack.
        ack_delay    = 2;
        fp.out_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        cyc();
        chk("sim_ack_pending", fp.rom_ack, 1);
        fp.redir_valid = 1'b1;
        fp.redir_pc    = 32'h100;
        cyc();
        fp.redir_valid = 1'b0;
        chk("sim_empty", fp.out_valid, 0);
        chk("sim_idle",  fp.rom_req,   0);
        cyc();
        chk("sim_req",  fp.rom_req,  1);
        chk("sim_addr", fp.rom_addr, 32'h100);

        // Asynchronous reset with a read in flight and three words buffered.
        ack_delay    = 0;
        fp.out_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        chk("ar_pre_req",   fp.rom_req,   1);
        chk("ar_pre_addr",  fp.rom_addr,  3);
        chk("ar_pre_valid", fp.out_valid, 1);
        #2;
        rst_n      = 1'b0;
        fp.rom_ack = 1'b0;
        wcnt       = 0;
        #1;
        chk("ar_rom_req",   fp.rom_req,   0);
        chk("ar_rom_addr",  fp.rom_addr,  0);
        chk("ar_out_valid", fp.out_valid, 0);
        chk("ar_out_data",  fp.out_data,  0);
        chk("ar_out_pc",    fp.out_pc,    0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("ar_restart_req",  fp.rom_req,  1);
        chk("ar_restart_addr", fp.rom_addr, 0);
        cyc();
        chk("ar_restart_valid", fp.out_valid, 1);
        chk("ar_restart_pc",    fp.out_pc,    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
